// File: rtl/decode_queue_ctrl.sv
// Registered instruction decoder feeding a small FIFO of control bundles.
// Sits between fetch and execute so execute stalls do not back-pressure decode logic directly.
module decode_queue_ctrl #(
    parameter int OP_W  = 6,
    parameter int FN_W  = 6,
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  opcode,
    input  logic [FN_W-1:0]  function_val,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       reg_dst,
    output logic             reg_write,
    output logic [1:0]       immediacy,
    output logic [2:0]       logic_fn,
    output logic [1:0]       functionals,
    output logic             data_read,
    output logic             data_write,
    output logic [1:0]       reg_input_data,
    output logic [3:0]       branch_type,
    output logic [1:0]       counter_selector,
    output logic             illegal,
    output logic [ERR_W-1:0] illegal_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic       illegal;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic [1:0] immediacy;
        logic [2:0] logic_fn;
        logic [1:0] functionals;
        logic       data_read;
        logic       data_write;
        logic [1:0] reg_input_data;
        logic [3:0] branch_type;
        logic [1:0] counter_selector;
    } bundle_t;

    bundle_t           dec;
    bundle_t           head;
    bundle_t           mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [ERR_W-1:0]  illegal_count_q;
    logic              push;
    logic              pop;

    // A transfer happens on an edge where valid and ready are both high on that side;
    // flush overrides both sides so nothing transfers in a flush cycle.
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        dec = '0;
        case (opcode)
            OP_W'(0): begin
                if (function_val <= FN_W'(6)) begin
                    dec.logic_fn  = function_val[2:0];
                    dec.reg_dst   = 2'b01;
                    dec.reg_write = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_W'(1): begin
                dec.immediacy = 2'b01;
                dec.reg_write = 1'b1;
            end
            OP_W'(2): begin
                dec.immediacy      = 2'b01;
                dec.data_read      = 1'b1;
                dec.reg_input_data = 2'b01;
                dec.reg_write      = 1'b1;
            end
            OP_W'(3): begin
                dec.immediacy  = 2'b01;
                dec.data_write = 1'b1;
            end
            OP_W'(4): begin
                dec.logic_fn         = 3'b001;
                dec.branch_type      = 4'd1;
                dec.counter_selector = 2'b01;
            end
            OP_W'(5): begin
                dec.counter_selector = 2'b10;
            end
            OP_W'(6): begin
                dec.reg_dst          = 2'b10;
                dec.reg_write        = 1'b1;
                dec.reg_input_data   = 2'b10;
                dec.counter_selector = 2'b10;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // Storage needs no reset: out_valid masks whatever it holds while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= dec;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // Survives flush on purpose so software can still see how many bad opcodes arrived.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_count_q <= '0;
        end else if (push && dec.illegal && (illegal_count_q != {ERR_W{1'b1}})) begin
            illegal_count_q <= illegal_count_q + 1'b1;
        end
    end

    assign head             = out_valid ? mem[rd_ptr_q] : '0;
    assign reg_dst          = head.reg_dst;
    assign reg_write        = head.reg_write;
    assign immediacy        = head.immediacy;
    assign logic_fn         = head.logic_fn;
    assign functionals      = head.functionals;
    assign data_read        = head.data_read;
    assign data_write       = head.data_write;
    assign reg_input_data   = head.reg_input_data;
    assign branch_type      = head.branch_type;
    assign counter_selector = head.counter_selector;
    assign illegal          = head.illegal;
    assign illegal_count    = illegal_count_q;

endmodule

// File: tb/tb_decode_queue_ctrl.sv
// Directed bench for decode_queue_ctrl: decode table, FIFO ordering, flush, illegal counting.
// A second instance with a 2-bit error counter shares all inputs to exercise saturation.
module tb_decode_queue_ctrl;
    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic [5:0] opcode;
    logic [5:0] function_val;
    logic       flush;
    logic       out_ready;

    logic       in_ready, out_valid, reg_write, data_read, data_write, illegal;
    logic [1:0] reg_dst, immediacy, functionals, reg_input_data, counter_selector;
    logic [2:0] logic_fn;
    logic [3:0] branch_type;
    logic [7:0] illegal_count;

    logic       in_ready_2, out_valid_2, reg_write_2, data_read_2, data_write_2, illegal_2;
    logic [1:0] reg_dst_2, immediacy_2, functionals_2, reg_input_data_2, counter_selector_2;
    logic [2:0] logic_fn_2;
    logic [3:0] branch_type_2;
    logic [1:0] illegal_count_2;

    logic [20:0] obs;
    logic [20:0] obs_2;

    int checks = 0;
    int fails  = 0;
    logic [20:0] exp_q[$];

    // Bundle layout: {illegal, reg_dst, reg_write, immediacy, logic_fn, functionals,
    //                 data_read, data_write, reg_input_data, branch_type, counter_selector}
    localparam logic [20:0] B_ZERO = 21'd0;
    localparam logic [20:0] B_ILL  = {1'b1, 20'd0};
    localparam logic [20:0] B_R1   = {1'b0, 2'b01, 1'b1, 2'b00, 3'b001, 2'b00, 1'b0, 1'b0, 2'b00, 4'd0, 2'b00};
    localparam logic [20:0] B_R3   = {1'b0, 2'b01, 1'b1, 2'b00, 3'b011, 2'b00, 1'b0, 1'b0, 2'b00, 4'd0, 2'b00};
    localparam logic [20:0] B_R5   = {1'b0, 2'b01, 1'b1, 2'b00, 3'b101, 2'b00, 1'b0, 1'b0, 2'b00, 4'd0, 2'b00};
    localparam logic [20:0] B_R6   = {1'b0, 2'b01, 1'b1, 2'b00, 3'b110, 2'b00, 1'b0, 1'b0, 2'b00, 4'd0, 2'b00};
    localparam logic [20:0] B_ADDI = {1'b0, 2'b00, 1'b1, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0, 2'b00, 4'd0, 2'b00};
    localparam logic [20:0] B_LW   = {1'b0, 2'b00, 1'b1, 2'b01, 3'b000, 2'b00, 1'b1, 1'b0, 2'b01, 4'd0, 2'b00};
    localparam logic [20:0] B_SW   = {1'b0, 2'b00, 1'b0, 2'b01, 3'b000, 2'b00, 1'b0, 1'b1, 2'b00, 4'd0, 2'b00};
    localparam logic [20:0] B_BEQ  = {1'b0, 2'b00, 1'b0, 2'b00, 3'b001, 2'b00, 1'b0, 1'b0, 2'b00, 4'd1, 2'b01};
    localparam logic [20:0] B_J    = {1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 2'b00, 4'd0, 2'b10};
    localparam logic [20:0] B_JAL  = {1'b0, 2'b10, 1'b1, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 2'b10, 4'd0, 2'b10};

    logic [5:0]  vec_op  [8];
    logic [5:0]  vec_fn  [8];
    logic [20:0] vec_exp [8];

    assign obs   = {illegal, reg_dst, reg_write, immediacy, logic_fn, functionals,
                    data_read, data_write, reg_input_data, branch_type, counter_selector};
    assign obs_2 = {illegal_2, reg_dst_2, reg_write_2, immediacy_2, logic_fn_2, functionals_2,
                    data_read_2, data_write_2, reg_input_data_2, branch_type_2, counter_selector_2};

    decode_queue_ctrl #(.OP_W(6), .FN_W(6), .DEPTH(4), .ERR_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .function_val(function_val), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .reg_dst(reg_dst),
        .reg_write(reg_write), .immediacy(immediacy), .logic_fn(logic_fn),
        .functionals(functionals), .data_read(data_read), .data_write(data_write),
        .reg_input_data(reg_input_data), .branch_type(branch_type),
        .counter_selector(counter_selector), .illegal(illegal), .illegal_count(illegal_count)
    );

    decode_queue_ctrl #(.OP_W(6), .FN_W(6), .DEPTH(4), .ERR_W(2)) dut_2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_2),
        .opcode(opcode), .function_val(function_val), .flush(flush),
        .out_valid(out_valid_2), .out_ready(out_ready), .reg_dst(reg_dst_2),
        .reg_write(reg_write_2), .immediacy(immediacy_2), .logic_fn(logic_fn_2),
        .functionals(functionals_2), .data_read(data_read_2), .data_write(data_write_2),
        .reg_input_data(reg_input_data_2), .branch_type(branch_type_2),
        .counter_selector(counter_selector_2), .illegal(illegal_2), .illegal_count(illegal_count_2)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic push(input logic [5:0] op, input logic [5:0] fn);
        in_valid     = 1'b1;
        opcode       = op;
        function_val = fn;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n  = 1'b0;
        in_valid = 1'b1;
        opcode   = 6'd2;
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
        checks++; if (obs !== B_ZERO) begin fails++; $display("FAIL reset_bundle: got %h exp %h", obs, B_ZERO); end
        checks++; if (illegal_count !== 8'd0) begin fails++; $display("FAIL reset_illegal_count: got %0d exp 0", illegal_count); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_holds_push: got %b exp 0", out_valid); end
        in_valid = 1'b0;
        reset_n  = 1'b1;
    endtask

    task automatic test_single();
        push(6'd0, 6'd1);
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_out_valid: got %b exp 1", out_valid); end
        checks++; if (obs !== B_R1) begin fails++; $display("FAIL single_bundle: got %h exp %h", obs, B_R1); end
        pop();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_empty: got %b exp 0", out_valid); end
        checks++; if (obs !== B_ZERO) begin fails++; $display("FAIL single_empty_bundle: got %h exp 0", obs); end
    endtask

    task automatic test_fill_drain();
        logic [20:0] exp_b [4];
        exp_b[0] = B_LW; exp_b[1] = B_SW; exp_b[2] = B_BEQ; exp_b[3] = B_JAL;
        push(6'd2, 6'd0);
        push(6'd3, 6'd0);
        push(6'd4, 6'd0);
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL fill_ready_at_3: got %b exp 1", in_ready); end
        push(6'd6, 6'd0);
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fill_full: got %b exp 0", in_ready); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL drain_valid_%0d: got %b exp 1", i, out_valid); end
            checks++; if (obs !== exp_b[i]) begin fails++; $display("FAIL drain_bundle_%0d: got %h exp %h", i, obs, exp_b[i]); end
            pop();
        end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_empty: got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int idx  = 0;
        int pops = 0;
        bit push_ok;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            push(vec_op[idx % 8], vec_fn[idx % 8]);
            exp_q.push_back(vec_exp[idx % 8]);
            idx++;
        end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_full: got %b exp 0", in_ready); end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            opcode       = vec_op[idx % 8];
            function_val = vec_fn[idx % 8];
            push_ok      = (exp_q.size() < 4);
            checks++; if (in_ready !== push_ok) begin fails++; $display("FAIL b2b_in_ready_c%0d: got %b exp %b", c, in_ready, push_ok); end
            checks++;
            if (exp_q.size() == 0) begin
                fails++; $display("FAIL b2b_underflow_c%0d: got empty scoreboard exp entry", c);
            end else if (out_valid !== 1'b1 || obs !== exp_q[0]) begin
                fails++; $display("FAIL b2b_head_c%0d: got v=%b %h exp v=1 %h", c, out_valid, obs, exp_q[0]);
            end
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                pops++;
            end
            if (push_ok) begin
                exp_q.push_back(vec_exp[idx % 8]);
                idx++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (pops !== 10) begin fails++; $display("FAIL b2b_throughput: got %0d exp 10", pops); end
        for (int guard = 0; guard < 8 && exp_q.size() > 0; guard++) begin
            checks++; if (obs !== exp_q[0]) begin fails++; $display("FAIL b2b_drain_%0d: got %h exp %h", guard, obs, exp_q[0]); end
            void'(exp_q.pop_front());
            pop();
        end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty: got %b exp 0", out_valid); end
    endtask

    task automatic test_illegal();
        do_reset();
        push(6'd9, 6'd0);
        push(6'd0, 6'd7);
        push(6'd0, 6'd6);
        checks++; if (illegal_count !== 8'd2) begin fails++; $display("FAIL illegal_count: got %0d exp 2", illegal_count); end
        checks++; if (obs !== B_ILL) begin fails++; $display("FAIL illegal_op9: got %h exp %h", obs, B_ILL); end
        pop();
        checks++; if (obs !== B_ILL) begin fails++; $display("FAIL illegal_fn7: got %h exp %h", obs, B_ILL); end
        pop();
        checks++; if (obs !== B_R6) begin fails++; $display("FAIL legal_fn6: got %h exp %h", obs, B_R6); end
        pop();
    endtask

    task automatic test_flush();
        push(6'd1, 6'd0);
        push(6'd0, 6'd2);
        push(6'd9, 6'd0);
        checks++; if (illegal_count !== 8'd3) begin fails++; $display("FAIL flush_pre_count: got %0d exp 3", illegal_count); end
        in_valid     = 1'b1;
        opcode       = 6'd2;
        function_val = 6'd0;
        out_ready    = 1'b1;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_out_valid: got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready: got %b exp 1", in_ready); end
        checks++; if (obs !== B_ZERO) begin fails++; $display("FAIL flush_bundle: got %h exp 0", obs); end
        checks++; if (illegal_count !== 8'd3) begin fails++; $display("FAIL flush_keeps_count: got %0d exp 3", illegal_count); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_dropped_incoming: got %b exp 0", out_valid); end
        push(6'd5, 6'd0);
        checks++; if (obs !== B_J) begin fails++; $display("FAIL flush_after_push: got %h exp %h", obs, B_J); end
        pop();
    endtask

    task automatic test_saturate_and_reset();
        logic [1:0] exp_sat [5];
        exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3; exp_sat[3] = 2'd3; exp_sat[4] = 2'd3;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(6'd9, 6'd0);
            checks++; if (illegal_count_2 !== exp_sat[i]) begin fails++; $display("FAIL sat_count_%0d: got %0d exp %0d", i, illegal_count_2, exp_sat[i]); end
        end
        checks++; if (illegal_count !== 8'd5) begin fails++; $display("FAIL wide_count: got %0d exp 5", illegal_count); end
        out_ready = 1'b0;
        pop();
        push(6'd1, 6'd0);
        push(6'd1, 6'd0);
        checks++; if (out_valid_2 !== 1'b1) begin fails++; $display("FAIL pre_reset_valid: got %b exp 1", out_valid_2); end
        in_valid = 1'b1;
        opcode   = 6'd2;
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid_2 !== 1'b0) begin fails++; $display("FAIL midreset_out_valid: got %b exp 0", out_valid_2); end
        checks++; if (in_ready_2 !== 1'b1) begin fails++; $display("FAIL midreset_in_ready: got %b exp 1", in_ready_2); end
        checks++; if (obs_2 !== B_ZERO) begin fails++; $display("FAIL midreset_bundle: got %h exp 0", obs_2); end
        checks++; if (illegal_count_2 !== 2'd0) begin fails++; $display("FAIL midreset_count: got %0d exp 0", illegal_count_2); end
        in_valid = 1'b0;
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_valid_2 !== 1'b0) begin fails++; $display("FAIL post_reset_empty: got %b exp 0", out_valid_2); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vec_op[0] = 6'd1; vec_fn[0] = 6'd0; vec_exp[0] = B_ADDI;
        vec_op[1] = 6'd2; vec_fn[1] = 6'd0; vec_exp[1] = B_LW;
        vec_op[2] = 6'd3; vec_fn[2] = 6'd0; vec_exp[2] = B_SW;
        vec_op[3] = 6'd4; vec_fn[3] = 6'd0; vec_exp[3] = B_BEQ;
        vec_op[4] = 6'd5; vec_fn[4] = 6'd0; vec_exp[4] = B_J;
        vec_op[5] = 6'd6; vec_fn[5] = 6'd0; vec_exp[5] = B_JAL;
        vec_op[6] = 6'd0; vec_fn[6] = 6'd3; vec_exp[6] = B_R3;
        vec_op[7] = 6'd0; vec_fn[7] = 6'd5; vec_exp[7] = B_R5;
        reset_n      = 1'b1;
        in_valid     = 1'b0;
        opcode       = 6'd0;
        function_val = 6'd0;
        flush        = 1'b0;
        out_ready    = 1'b0;
        #2;
        test_reset();
        test_single();
        test_fill_drain();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_saturate_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
